// File: rtl/funny_pkg.sv
// Shared execute-path constants and types, common to the ALU, the decoder and the register file.
package funny_pkg;

  localparam int WIDTH  = 32;
  localparam int NREGS  = 32;
  localparam int AW     = 5;
  localparam int NPORTS = 2;

  typedef logic [AW-1:0] reg_addr_t;

endpackage

// File: rtl/reg_file_wb_if.sv
// Read-port, write-back and stall signals between the execute stage and reg_file_wb.
interface reg_file_wb_if
  import funny_pkg::*;
#(
  parameter int WIDTH = funny_pkg::WIDTH,
  parameter int AW    = funny_pkg::AW
);
  logic [AW-1:0]    rd_addr1;
  logic [AW-1:0]    rd_addr2;
  logic [WIDTH-1:0] rd_data1;
  logic [WIDTH-1:0] rd_data2;
  logic             wb_valid;
  logic             wb_ready;
  logic [AW-1:0]    wb_addr;
  logic [WIDTH-1:0] wb_data;
  logic             hold;
  logic             hazard1;
  logic             hazard2;

  modport master (
    output rd_addr1, rd_addr2, wb_valid, wb_addr, wb_data, hold,
    input  rd_data1, rd_data2, wb_ready, hazard1, hazard2
  );

  modport slave (
    input  rd_addr1, rd_addr2, wb_valid, wb_addr, wb_data, hold,
    output rd_data1, rd_data2, wb_ready, hazard1, hazard2
  );
endinterface

// File: rtl/reg_fwd_port.sv
// One read port: selects array vs. pending data and flags reads of a not-yet-committed write.
// REG_FILE_WB_BYPASS_EN forwards the pending value instead of raising a hazard.
module reg_fwd_port
  import funny_pkg::*;
#(
  parameter int WIDTH = funny_pkg::WIDTH,
  parameter int NREGS = funny_pkg::NREGS,
  parameter int AW    = funny_pkg::AW
) (
  input  logic [AW-1:0]    rd_addr,
  input  logic [WIDTH-1:0] arr_data,
  input  logic             pend_valid,
  input  logic [AW-1:0]    pend_addr,
  input  logic [WIDTH-1:0] pend_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             hazard
);
  localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

  // Out-of-range pending writes never commit, so they must never match a read.
  logic pend_hit;
  assign pend_hit = pend_valid && (pend_addr == rd_addr) && ({1'b0, pend_addr} < NREGS_W);

`ifdef REG_FILE_WB_BYPASS_EN
  assign rd_data = pend_hit ? pend_data : arr_data;
  assign hazard  = 1'b0;
`else
  logic unused_pend_data;
  assign unused_pend_data = ^pend_data;
  assign rd_data = arr_data;
  assign hazard  = pend_hit;
`endif

endmodule

// File: rtl/reg_file_wb.sv
// Register file with a one-entry pending write-back register ahead of the array.
// Optional macro REG_FILE_WB_BYPASS_EN: reads forward the pending value, hazards tie low.
module reg_file_wb
  import funny_pkg::*;
#(
  parameter int WIDTH = funny_pkg::WIDTH,
  parameter int NREGS = funny_pkg::NREGS,
  parameter int AW    = funny_pkg::AW
) (
  input  logic          clk,
  input  logic          rst,
  reg_file_wb_if.slave  bus
);
  localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

  logic [WIDTH-1:0] mem [NREGS];

  logic             pend_valid;
  logic [AW-1:0]    pend_addr;
  logic [WIDTH-1:0] pend_data;
  logic             pend_in_range;

  logic [NPORTS-1:0][AW-1:0]    rd_addr_v;
  logic [NPORTS-1:0][WIDTH-1:0] arr_data_v;
  logic [NPORTS-1:0][WIDTH-1:0] rd_data_v;
  logic [NPORTS-1:0]            hazard_v;

  assign bus.wb_ready  = !bus.hold;
  assign pend_in_range = {1'b0, pend_addr} < NREGS_W;

  // Pending register: hold freezes it; otherwise it tracks whatever is accepted this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= '0;
    end else if (!bus.hold) begin
      pend_valid <= bus.wb_valid;
      if (bus.wb_valid) begin
        pend_addr <= bus.wb_addr;
        pend_data <= bus.wb_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (!bus.hold && pend_valid && pend_in_range) begin
      mem[pend_addr] <= pend_data;
    end
  end

  assign rd_addr_v = {bus.rd_addr2, bus.rd_addr1};

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    assign arr_data_v[p] = ({1'b0, rd_addr_v[p]} < NREGS_W) ? mem[rd_addr_v[p]] : '0;

    reg_fwd_port #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW)) u_port (
      .rd_addr    (rd_addr_v[p]),
      .arr_data   (arr_data_v[p]),
      .pend_valid (pend_valid),
      .pend_addr  (pend_addr),
      .pend_data  (pend_data),
      .rd_data    (rd_data_v[p]),
      .hazard     (hazard_v[p])
    );
  end

  assign bus.rd_data1 = rd_data_v[0];
  assign bus.rd_data2 = rd_data_v[1];
  assign bus.hazard1  = hazard_v[0];
  assign bus.hazard2  = hazard_v[1];

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed bench for reg_file_wb (NREGS=24 so address 30 is out of range); expectations queued per cycle.
module tb_reg_file_wb;
  import funny_pkg::*;

`ifdef REG_FILE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  reg_file_wb_if #(.WIDTH(32), .AW(5)) bus ();

  reg_file_wb #(.WIDTH(32), .NREGS(24), .AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] observe(int sel);
    case (sel)
      0:       return bus.rd_data1;
      1:       return bus.rd_data2;
      2:       return 32'(bus.hazard1);
      3:       return 32'(bus.hazard2);
      default: return 32'(bus.wb_ready);
    endcase
  endfunction

  task automatic push(string tag, int sel, logic [31:0] val);
    exp_t e;
    e.tag = tag; e.sel = sel; e.val = val;
    sb.push_back(e);
  endtask

  // port 0/1: data and hazard expectations for that read port
  task automatic exp_rd(string tag, int port, logic [31:0] data, logic hz);
    push({tag, "_data"}, port, data);
    push({tag, "_hz"}, 2 + port, 32'(hz));
  endtask

  task automatic check_and_tick();
    exp_t e;
    logic [31:0] obs;
    #3;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = observe(e.sel);
      tests++;
      assert (obs === e.val) else begin
        fails++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wb(logic v, logic [4:0] a, logic [31:0] d);
    bus.wb_valid = v; bus.wb_addr = a; bus.wb_data = d;
  endtask

  initial begin
    rst = 1'b1;
    bus.hold = 1'b0; bus.rd_addr1 = '0; bus.rd_addr2 = '0;
    wb(1'b0, 5'd0, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // reset state
    bus.rd_addr2 = 5'd5;
    exp_rd("rst_p1", 0, 32'h0, 1'b0);
    exp_rd("rst_p2", 1, 32'h0, 1'b0);
    push("rst_ready", 4, 32'h1);
    check_and_tick();

    // reset clears a committed value and discards a pending one
    wb(1'b1, 5'd3, 32'hDEADBEEF); check_and_tick();
    wb(1'b0, 5'd0, 32'h0);        check_and_tick();
    bus.rd_addr1 = 5'd3;
    wb(1'b1, 5'd3, 32'h11111111); rst = 1'b1;
    exp_rd("r3_before_rst", 0, 32'hDEADBEEF, 1'b0);
    check_and_tick();
    rst = 1'b0; wb(1'b0, 5'd0, 32'h0);
    exp_rd("r3_after_rst", 0, 32'h0, 1'b0);
    check_and_tick();
    exp_rd("r3_no_commit", 0, 32'h0, 1'b0);
    check_and_tick();

    // basic latency
    bus.rd_addr1 = 5'd5;
    wb(1'b1, 5'd5, 32'h12345678);
    exp_rd("r5_n", 0, 32'h0, 1'b0);
    check_and_tick();
    wb(1'b0, 5'd0, 32'h0);
    exp_rd("r5_n1", 0, BYP ? 32'h12345678 : 32'h0, !BYP);
    check_and_tick();
    exp_rd("r5_n2", 0, 32'h12345678, 1'b0);
    check_and_tick();

    // back-to-back writes to r7
    bus.rd_addr1 = 5'd7;
    wb(1'b1, 5'd7, 32'h1);
    exp_rd("r7_n", 0, 32'h0, 1'b0);
    check_and_tick();
    wb(1'b1, 5'd7, 32'h2);
    exp_rd("r7_n1", 0, BYP ? 32'h1 : 32'h0, !BYP);
    check_and_tick();
    wb(1'b0, 5'd0, 32'h0);
    exp_rd("r7_n2", 0, BYP ? 32'h2 : 32'h1, !BYP);
    check_and_tick();
    exp_rd("r7_n3", 0, 32'h2, 1'b0);
    check_and_tick();
    exp_rd("r7_n4", 0, 32'h2, 1'b0);
    check_and_tick();

    // hold freezes pending r9 and blocks acceptance of r10
    bus.rd_addr1 = 5'd9; bus.rd_addr2 = 5'd10;
    wb(1'b1, 5'd9, 32'hAA);
    exp_rd("r9_n", 0, 32'h0, 1'b0);
    check_and_tick();
    bus.hold = 1'b1;
    wb(1'b1, 5'd10, 32'hBB);
    for (int i = 0; i < 3; i++) begin
      exp_rd("r9_hold", 0, BYP ? 32'hAA : 32'h0, !BYP);
      exp_rd("r10_hold", 1, 32'h0, 1'b0);
      push("ready_hold", 4, 32'h0);
      check_and_tick();
    end
    bus.hold = 1'b0;
    exp_rd("r9_n4", 0, BYP ? 32'hAA : 32'h0, !BYP);
    exp_rd("r10_n4", 1, 32'h0, 1'b0);
    push("ready_release", 4, 32'h1);
    check_and_tick();
    wb(1'b0, 5'd0, 32'h0);
    exp_rd("r9_n5", 0, 32'hAA, 1'b0);
    exp_rd("r10_n5", 1, BYP ? 32'hBB : 32'h0, !BYP);
    check_and_tick();
    exp_rd("r9_n6", 0, 32'hAA, 1'b0);
    exp_rd("r10_n6", 1, 32'hBB, 1'b0);
    check_and_tick();

    // dual port on the same pending address, then out-of-range and last-register writes
    bus.rd_addr1 = 5'd4; bus.rd_addr2 = 5'd4;
    wb(1'b1, 5'd4, 32'h44);
    exp_rd("r4_p1_n", 0, 32'h0, 1'b0);
    exp_rd("r4_p2_n", 1, 32'h0, 1'b0);
    check_and_tick();
    wb(1'b1, 5'd30, 32'hCAFE);
    exp_rd("r4_p1_pend", 0, BYP ? 32'h44 : 32'h0, !BYP);
    exp_rd("r4_p2_pend", 1, BYP ? 32'h44 : 32'h0, !BYP);
    check_and_tick();
    bus.rd_addr1 = 5'd30;
    wb(1'b1, 5'd23, 32'h2323);
    exp_rd("a30_pend", 0, 32'h0, 1'b0);
    exp_rd("r4_p2_done", 1, 32'h44, 1'b0);
    check_and_tick();
    wb(1'b0, 5'd0, 32'h0);
    bus.rd_addr2 = 5'd6;
    exp_rd("a30_dropped", 0, 32'h0, 1'b0);
    exp_rd("r6_no_alias", 1, 32'h0, 1'b0);
    check_and_tick();
    bus.rd_addr1 = 5'd23; bus.rd_addr2 = 5'd24;
    exp_rd("r23", 0, 32'h2323, 1'b0);
    exp_rd("a24", 1, 32'h0, 1'b0);
    check_and_tick();

    // reset mid-operation discards pending r2 and clears the array
    bus.rd_addr1 = 5'd2; bus.rd_addr2 = 5'd9;
    wb(1'b1, 5'd2, 32'h55);
    exp_rd("r2_n", 0, 32'h0, 1'b0);
    check_and_tick();
    wb(1'b0, 5'd0, 32'h0); rst = 1'b1;
    exp_rd("r2_n1", 0, BYP ? 32'h55 : 32'h0, !BYP);
    exp_rd("r9_pre_rst", 1, 32'hAA, 1'b0);
    check_and_tick();
    rst = 1'b0;
    exp_rd("r2_n2", 0, 32'h0, 1'b0);
    exp_rd("r9_post_rst", 1, 32'h0, 1'b0);
    check_and_tick();
    exp_rd("r2_n3", 0, 32'h0, 1'b0);
    check_and_tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- Register file plus write-back stage for the execute path.
- Two combinational read ports drive the ALU's in1/in2 operands; one write-back port consumes the ALU result.
- Each write is held for one cycle in a pending register before it commits to the array.
- A hazard indication or a bypass path covers the window while a write is pending.

Parameters:
- WIDTH, 32, data width of each register (matches the ALU operand width).
- NREGS, 32, number of architectural registers.
- AW, 5, register address width; must satisfy 2**AW >= NREGS.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- rd_addr1  input  AW  read port 1 address.
- rd_data1  output  WIDTH  read port 1 data, combinational; feeds ALU in1.
- rd_addr2  input  AW  read port 2 address.
- rd_data2  output  WIDTH  read port 2 data, combinational; feeds ALU in2.
- wb_valid  input  1  write-back request; carries the ALU out value.
- wb_ready  output  1  stage can accept a write-back; combinational, equals !hold.
- wb_addr  input  AW  destination register.
- wb_data  input  WIDTH  value to write.
- hold  input  1  stall; freezes the pending register and blocks commit.
- hazard1  output  1  rd_addr1 matches a valid pending write whose value is not yet readable.
- hazard2  output  1  same as hazard1, for port 2.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, rst.
- Reset (rst high at an edge):
  - all NREGS registers cleared to 0;
  - pend_valid, pend_addr and pend_data cleared to 0.
  - After reset: rd_data1/2 = 0, hazard1/2 = 0, wb_ready = !hold.
- rst has priority over everything. Reset mid-operation discards the pending write; it never commits.
- Accept: a write-back is accepted at an edge when wb_valid && wb_ready. pend_valid, pend_addr and pend_data load from wb_valid, wb_addr and wb_data.
- Edge with hold = 0 and no accept: pend_valid <= 0.
- Commit: at every edge with hold = 0 and pend_valid = 1, array[pend_addr] <= pend_data. This is the same edge at which a new write may load pending; both happen together.
- Latency:
  - write presented in cycle N;
  - in pending during cycle N+1;
  - array updated at the end of N+1, so the array value is readable in N+2.
- hold = 1: pending state and the array are unchanged, and nothing is accepted (wb_ready = 0). The upstream stage must keep wb_valid and its payload stable.
- Reads:
  - rd_dataX = array[rd_addrX] when rd_addrX < NREGS;
  - rd_dataX = 0 when rd_addrX >= NREGS.
  - Reads never see wb_data from the same cycle; there is no bypass from the wb_* inputs.
- Out-of-range writes (wb_addr >= NREGS): accepted and held in pending, but the commit is dropped. No hazard or bypass match is produced for them.
- Back-to-back writes to the same address in N and N+1: the N+1 value wins. The array ends with the later value at the end of N+2.
- Both read ports hitting the same pending address: both ports get identical treatment.
- There is no hardwired zero register; every register is writable.

Optional Feature:
- Macro: REG_FILE_WB_BYPASS_EN.
- Defined:
  - rd_dataX = pend_data when pend_valid && pend_addr == rd_addrX && pend_addr < NREGS; otherwise the array value. Pending has priority over the array.
  - hazard1 and hazard2 are tied to 0.
  - The effective read-after-write latency becomes 1 cycle (readable in N+1).
- Not defined:
  - rd_dataX always comes from the array (the stale value while a write is pending).
  - hazardX = pend_valid && pend_addr == rd_addrX && pend_addr < NREGS.
  - The issuing stage must stall on hazard.

Decomposition:
- Shared package funny_pkg: WIDTH and AW constants, NREGS constant, and a reg_addr_t typedef for register addresses. The ALU and the decoder use the same package.
- One sub-module is natural: reg_fwd_port. It takes a read address, the array data, pend_valid, pend_addr and pend_data, and produces rd_data plus hazard. It is instantiated once per read port and contains the macro-dependent logic.

Test Plan:
- Reset: write 0xDEADBEEF to r3 and let it commit; assert rst for one edge; read r3 -> 0x00000000; hazard1/2 = 0; no commit occurs after reset.
- Basic write/read latency: wb r5 = 0x12345678 in cycle N.
  - Without bypass: rd_addr1 = 5 in N+1 gives old value 0 with hazard1 = 1; in N+2 it gives 0x12345678 with hazard1 = 0.
  - With bypass: 0x12345678 already in N+1, hazard1 = 0.
- Back-to-back: wb r7 = 0x1 in N, then r7 = 0x2 in N+1 -> r7 reads 0x2 from N+3 onward (N+2 with bypass); it never reads 0x1 after N+2.
- Hold: wb r9 = 0xAA in N; hold = 1 during N+1..N+3 -> wb_ready = 0 and r9 stays 0 (bypass: 0xAA) through N+3; hold drops and r9 = 0xAA from N+5.
- Dual port/out of range: rd_addr1 = rd_addr2 = 4 with r4 pending -> both ports behave identically. With NREGS = 24, a wb to address 30 is dropped; reading address 30 returns 0 with no hazard.
- Reset mid-operation: wb r2 = 0x55 in N; rst high at the end of N+1 -> r2 = 0 and pend_valid = 0 in N+2.
